// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and
// D-cache controllers. The grant is held until memory completes, the D side
// may lock the port for a bounded number of back-to-back transactions, and a
// watchdog releases the port if memory never completes.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 64,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8,
  parameter int MAX_LOCK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_rd_wrt,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_rd_wrt,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_rd_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_i,
  output logic              grant_d,
  output logic              timeout_err
);

  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;     // 1: D side owned the port last
  logic [CNT_W-1:0]  wd_cnt, wd_cnt_nxt;
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
  logic              own_d;

  // State register: owner, round-robin history, watchdog and lock counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, regardless of statement order.
      state    <= IDLE;
      last_d   <= 1'b0;
      wd_cnt   <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      wd_cnt   <= wd_cnt_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Next-state arbitration plus the memory-port mux and completion outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nxt    = state;
    last_d_nxt   = last_d;
    wd_cnt_nxt   = wd_cnt;
    lock_cnt_nxt = lock_cnt;
    own_d        = (state == GNT_D);
    mem_en       = 1'b0;
    mem_rd_wrt   = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rdata        = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    timeout_err  = 1'b0;

    case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        if (i_req && d_req) state_nxt = last_d ? GNT_I : GNT_D;
        else if (d_req)     state_nxt = GNT_D;
        else if (i_req)     state_nxt = GNT_I;
      end
      GNT_I, GNT_D: begin
        mem_en     = own_d ? d_req    : i_req;
        mem_rd_wrt = own_d ? d_rd_wrt : i_rd_wrt;
        mem_addr   = own_d ? d_addr   : i_addr;
        mem_wdata  = own_d ? d_wdata  : i_wdata;
        rdata      = mem_rdata;
        if (mem_done) begin
          // A completion always wins over a watchdog expiry in the same cycle.
          i_done     = !own_d;
          d_done     = own_d;
          last_d_nxt = own_d;
          if (own_d && d_lock && (lock_cnt < LOCK_W'(MAX_LOCK))) begin
            lock_cnt_nxt = lock_cnt + LOCK_W'(1);
            wd_cnt_nxt   = '0;
          end else begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end
        end else if (wd_cnt == CNT_W'(TIMEOUT)) begin
          timeout_err  = 1'b1;
          last_d_nxt   = own_d;
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset silences the port immediately; the grant itself drops next cycle.
    if (rst) begin
      mem_en      = 1'b0;
      mem_rd_wrt  = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      rdata       = '0;
      i_done      = 1'b0;
      d_done      = 1'b0;
      timeout_err = 1'b0;
    end
  end

  assign grant_i = (state == GNT_I);
  assign grant_d = (state == GNT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-level
// model of port ownership.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 64;
  localparam int TIMEOUT  = 8;
  localparam int CNT_W    = 8;
  localparam int MAX_LOCK = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0, i_rd_wrt = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [DATA_W-1:0] i_wdata = '0;
  logic              i_done;
  logic              d_req = 1'b0, d_rd_wrt = 1'b0, d_lock = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_rd_wrt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              grant_i, grant_d, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_rd_wrt(i_rd_wrt), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_done(i_done),
    .d_req(d_req), .d_rd_wrt(d_rd_wrt), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_done(d_done),
    .rdata(rdata),
    .mem_en(mem_en), .mem_rd_wrt(mem_rd_wrt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .grant_i(grant_i), .grant_d(grant_d), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- ownership model ----------------
  // owner: 0 = nobody, 1 = I side, 2 = D side; age = cycles spent in this grant.
  int m_owner = 0;
  bit m_last_d = 1'b0;
  int m_age = 0;
  int m_locks = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= 0; m_last_d <= 1'b0; m_age <= 0; m_locks <= 0;
    end else if (m_owner == 0) begin
      m_age <= 0;
      if (i_req && d_req) m_owner <= m_last_d ? 1 : 2;
      else if (d_req)     m_owner <= 2;
      else if (i_req)     m_owner <= 1;
    end else if (mem_done) begin
      m_last_d <= (m_owner == 2);
      if (m_owner == 2 && d_lock && m_locks < MAX_LOCK) begin
        m_locks <= m_locks + 1;
        m_age   <= 0;
      end else begin
        m_owner <= 0;
        m_locks <= 0;
      end
    end else if (m_age == TIMEOUT) begin
      m_last_d <= (m_owner == 2);
      m_owner  <= 0;
      m_locks  <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : cmp
    bit              act, side_d;
    logic [DATA_W-1:0] e_wdata;
    if (chk_en) begin
      act    = !rst && (m_owner != 0);
      side_d = (m_owner == 2);
      e_wdata = act ? (side_d ? d_wdata : i_wdata) : '0;
      check("grant_i", 64'(grant_i), 64'(m_owner == 1));
      check("grant_d", 64'(grant_d), 64'(m_owner == 2));
      check("mem_en", 64'(mem_en), 64'(act && (side_d ? d_req : i_req)));
      check("mem_rd_wrt", 64'(mem_rd_wrt), 64'(act && (side_d ? d_rd_wrt : i_rd_wrt)));
      check("mem_addr", 64'(mem_addr), act ? 64'(side_d ? d_addr : i_addr) : 64'd0);
      check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      check("i_done", 64'(i_done), 64'(act && !side_d && mem_done));
      check("d_done", 64'(d_done), 64'(act && side_d && mem_done));
      check("timeout_err", 64'(timeout_err), 64'(act && !mem_done && m_age == TIMEOUT));
      check("rdata", 64'(rdata), act ? 64'(mem_rdata) : 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // T1: reset, then a lone I request at 0x0040 completing after 4 cycles.
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    smp();
    check("T1 reset mem_en", 64'(mem_en), 64'd0);
    check("T1 reset mem_addr", 64'(mem_addr), 64'd0);
    nxt(); rst = 1'b0; i_req = 1'b1; i_rd_wrt = 1'b1; i_addr = 16'h0040;
    smp(); check("T1 no grant yet", 64'(grant_i), 64'd0);
    nxt(); smp();
    check("T1 grant_i", 64'(grant_i), 64'd1);
    check("T1 mem_en", 64'(mem_en), 64'd1);
    check("T1 mem_addr", 64'(mem_addr), 64'h0040);
    repeat (3) nxt();
    nxt(); mem_done = 1'b1; mem_rdata = 64'hCAFE_F00D_1234_5678;
    smp();
    check("T1 i_done", 64'(i_done), 64'd1);
    check("T1 rdata", 64'(rdata), 64'hCAFE_F00D_1234_5678);
    nxt(); mem_done = 1'b0; i_req = 1'b0;
    smp();
    check("T1 i_done pulse", 64'(i_done), 64'd0);
    check("T1 idle", 64'(grant_i), 64'd0);

    // T2: simultaneous requests after reset; D wins first, ties alternate.
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    nxt(); i_req = 1'b1; d_req = 1'b1; d_rd_wrt = 1'b1; d_addr = 16'h0100;
    nxt(); smp();
    check("T2 D first", 64'(grant_d), 64'd1);
    check("T2 I waits", 64'(grant_i), 64'd0);
    nxt(); mem_done = 1'b1;
    smp(); check("T2 d_done", 64'(d_done), 64'd1);
    nxt(); mem_done = 1'b0;
    smp(); check("T2 idle gap", 64'(grant_i), 64'd0);
    nxt(); smp(); check("T2 then I", 64'(grant_i), 64'd1);
    nxt(); mem_done = 1'b1;
    smp(); check("T2 i_done", 64'(i_done), 64'd1);
    nxt(); mem_done = 1'b0;
    nxt(); smp(); check("T2 tie goes to D", 64'(grant_d), 64'd1);
    nxt(); mem_done = 1'b1;
    nxt(); mem_done = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // T3: D refill locked into writeback; third locked done releases.
    nxt(); d_req = 1'b1; d_rd_wrt = 1'b1; d_addr = 16'h0200;
    nxt(); nxt(); mem_done = 1'b1; d_lock = 1'b1;
    smp(); check("T3 refill done", 64'(d_done), 64'd1);
    nxt(); mem_done = 1'b0; d_lock = 1'b0; d_rd_wrt = 1'b0; d_wdata = 64'h0123_4567_89AB_CDEF;
    smp();
    check("T3 grant held", 64'(grant_d), 64'd1);
    check("T3 writeback op", 64'(mem_rd_wrt), 64'd0);
    check("T3 writeback data", 64'(mem_wdata), 64'h0123_4567_89AB_CDEF);
    nxt(); mem_done = 1'b1; d_lock = 1'b1;
    nxt(); mem_done = 1'b0;
    smp(); check("T3 second lock held", 64'(grant_d), 64'd1);
    nxt(); mem_done = 1'b1;
    nxt(); mem_done = 1'b0; d_lock = 1'b0; d_req = 1'b0;
    smp(); check("T3 lock limit releases", 64'(grant_d), 64'd0);

    // T4: withheld mem_done triggers the watchdog on the 9th grant cycle.
    nxt(); d_req = 1'b1;
    nxt(); smp(); check("T4 granted", 64'(grant_d), 64'd1);
    for (int k = 1; k < TIMEOUT; k++) nxt();
    smp(); check("T4 no early timeout", 64'(timeout_err), 64'd0);
    nxt(); smp();
    check("T4 timeout_err", 64'(timeout_err), 64'd1);
    check("T4 no d_done", 64'(d_done), 64'd0);
    nxt(); d_req = 1'b0;
    smp();
    check("T4 timeout pulse", 64'(timeout_err), 64'd0);
    check("T4 idle", 64'(grant_d), 64'd0);

    // T5: reset mid-grant, then a stray mem_done.
    nxt(); i_req = 1'b1;
    nxt(); nxt(); rst = 1'b1;
    smp(); check("T5 mem_en in reset", 64'(mem_en), 64'd0);
    nxt(); rst = 1'b0; i_req = 1'b0; mem_done = 1'b1;
    smp();
    check("T5 grant dropped", 64'(grant_i), 64'd0);
    check("T5 stray done ignored", 64'(i_done), 64'd0);
    nxt(); mem_done = 1'b0;

    // T6: done in the timeout cycle wins; done in IDLE is ignored.
    nxt(); i_req = 1'b1;
    nxt();
    for (int k = 0; k < TIMEOUT; k++) nxt();
    mem_done = 1'b1;
    smp();
    check("T6 i_done at timeout", 64'(i_done), 64'd1);
    check("T6 no timeout_err", 64'(timeout_err), 64'd0);
    nxt(); mem_done = 1'b0; i_req = 1'b0;
    nxt(); mem_done = 1'b1;
    smp();
    check("T6 idle i_done", 64'(i_done), 64'd0);
    check("T6 idle d_done", 64'(d_done), 64'd0);
    nxt(); mem_done = 1'b0;

    // Randomized traffic, including protocol violations and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      nxt();
      rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) i_req = !i_req;
      if ($urandom_range(0, 3) == 0) d_req = !d_req;
      i_rd_wrt  = 1'($urandom_range(0, 1));
      d_rd_wrt  = 1'($urandom_range(0, 1));
      d_lock    = 1'($urandom_range(0, 1));
      i_addr    = 16'($urandom);
      d_addr    = 16'($urandom);
      i_wdata   = {$urandom, $urandom};
      d_wdata   = {$urandom, $urandom};
      mem_done  = ($urandom_range(0, 4) == 0);
      mem_rdata = {$urandom, $urandom};
    end
    nxt();
    smp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
